data_mem_responder: RTL and testbench

Data-memory responder for the pipelined RISC-V core's MEM stage. It accepts one load or store request at a time over a valid/ready handshake and models a fixed, parameterised access latency. It performs RV32I byte, halfword and word accesses with load sign/zero extension, and returns a single-cycle response. The MEM stage is the initiator and holds the pipeline stalled from request until response.

---
 rtl/data_mem_responder_if.sv | 30 +++
 rtl/data_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// ============================================================================
// data_mem_responder_if : MEM-stage request/response bus to the data memory
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface data_mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder : fixed-latency RV32I data memory with byte/half/word
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  mem_if
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    funct3_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH];

  logic          accept, enter_resp;
  logic          a_write;
  logic [AW+1:0] a_addr;
  logic [31:0]   a_wdata;
  logic [2:0]    a_f3;
  logic [31:0]   word, shifted, load_data, lanes, merged;
  logic [3:0]    be;
  logic          misalign, illegal, access_err;
  logic          addr_hi_unused;

  assign addr_hi_unused = ^mem_if.req_addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_if.req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
    end else if (accept) begin
      write_q  <= mem_if.req_write;
      addr_q   <= mem_if.req_addr[AW+1:0];
      wdata_q  <= mem_if.req_wdata;
      funct3_q <= mem_if.req_funct3;
    end
  end

  // With LATENCY=1 the access edge is the acceptance edge, so use the live bus.
  assign a_write = (state_q == S_IDLE) ? mem_if.req_write           : write_q;
  assign a_addr  = (state_q == S_IDLE) ? mem_if.req_addr[AW+1:0]    : addr_q;
  assign a_wdata = (state_q == S_IDLE) ? mem_if.req_wdata           : wdata_q;
  assign a_f3    = (state_q == S_IDLE) ? mem_if.req_funct3          : funct3_q;

  assign word    = mem_q[a_addr[AW+1:2]];
  assign shifted = word >> {a_addr[1:0], 3'b000};

  always_comb begin
    misalign = ((a_f3[1:0] == 2'b01) && a_addr[0]) ||
               ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
    if (a_write) illegal = !(a_f3 inside {3'b000, 3'b001, 3'b010});
    else         illegal = (a_f3 inside {3'b011, 3'b110, 3'b111});
    access_err = misalign || illegal;
  end

  always_comb begin
    load_data = 32'd0;
    case (a_f3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = word;
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    lanes = a_wdata;
    case (a_f3)
      3'b000: begin
        be    = 4'b0001 << a_addr[1:0];
        lanes = {4{a_wdata[7:0]}};
      end
      3'b001: begin
        be    = 4'b0011 << {a_addr[1], 1'b0};
        lanes = {2{a_wdata[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    merged = word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = lanes[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && a_write && !access_err) begin
      mem_q[a_addr[AW+1:2]] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= access_err;
      rdata_q <= (a_write || access_err) ? 32'd0 : load_data;
    end else begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end
  end

  assign mem_if.req_ready  = (state_q == S_IDLE);
  assign mem_if.resp_valid = (state_q == S_RESP);
  assign mem_if.resp_rdata = rdata_q;
  assign mem_if.resp_err   = err_q;
  assign mem_if.stall      = mem_if.req_valid & ~mem_if.resp_valid;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// tb_data_mem_responder : directed checks for LATENCY=2 and LATENCY=1 builds
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if u_if2();
  data_mem_responder_if u_if1();

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_dut2 (
    .clk    (clk),
    .rst    (rst),
    .mem_if (u_if2.slave)
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .mem_if (u_if1.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit l1, input logic v, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    if (l1) begin
      u_if1.req_valid = v; u_if1.req_write = wr; u_if1.req_addr = a;
      u_if1.req_wdata = d; u_if1.req_funct3 = f;
    end else begin
      u_if2.req_valid = v; u_if2.req_write = wr; u_if2.req_addr = a;
      u_if2.req_wdata = d; u_if2.req_funct3 = f;
    end
  endtask

  task automatic run_req(input bit l1, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f,
                         output logic [31:0] rd, output logic er,
                         output int cyc, output int stl);
    int guard;
    bit got;
    rd = 32'd0; er = 1'b0; cyc = 0; stl = 0; got = 1'b0; guard = 0;
    @(negedge clk);
    while (!(l1 ? u_if1.req_ready : u_if2.req_ready) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    drive(l1, 1'b1, wr, a, d, f);
    #1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (l1 ? u_if1.stall : u_if2.stall) stl++;
      @(posedge clk);
      #1;
      cyc++;
      if (l1 ? u_if1.resp_valid : u_if2.resp_valid) begin
        got = 1'b1;
        rd  = l1 ? u_if1.resp_rdata : u_if2.resp_rdata;
        er  = l1 ? u_if1.resp_err   : u_if2.resp_err;
      end
    end
    check_val("resp_seen", {31'd0, got}, 32'd1);
    drive(l1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc, stl, vcnt;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", u_if2.req_ready, 32'd1);
    check_val("rst_valid", u_if2.resp_valid, 32'd0);
    check_val("rst_rdata", u_if2.resp_rdata, 32'd0);
    check_val("rst_err",   u_if2.resp_err, 32'd0);
    check_val("rst_stall", u_if2.stall, 32'd0);
    rst = 1'b0;

    run_req(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, cyc, stl);
    check_val("sw_err", er, 0); check_val("sw_lat", cyc, 2); check_val("sw_stall", stl, 2);
    check_val("sw_rdata", rd, 0);
    run_req(0, 0, 32'h10, 32'h0, 3'b010, rd, er, cyc, stl);
    check_val("lw_data", rd, 32'hDEADBEEF); check_val("lw_lat", cyc, 2); check_val("lw_stall", stl, 2);
    @(posedge clk); #1;
    check_val("rdata_idle", u_if2.resp_rdata, 0);

    run_req(0, 0, 32'h13, 32'h0, 3'b000, rd, er, cyc, stl); check_val("lb_13", rd, 32'hFFFFFFDE);
    run_req(0, 0, 32'h13, 32'h0, 3'b100, rd, er, cyc, stl); check_val("lbu_13", rd, 32'h000000DE);
    run_req(0, 0, 32'h10, 32'h0, 3'b001, rd, er, cyc, stl); check_val("lh_10", rd, 32'hFFFFBEEF);
    run_req(0, 0, 32'h12, 32'h0, 3'b101, rd, er, cyc, stl); check_val("lhu_12", rd, 32'h0000DEAD);

    run_req(0, 1, 32'h11, 32'hFFFFFF55, 3'b000, rd, er, cyc, stl); check_val("sb_err", er, 0);
    run_req(0, 0, 32'h10, 32'h0, 3'b010, rd, er, cyc, stl); check_val("lw_after_sb", rd, 32'hDEAD55EF);
    run_req(0, 1, 32'h12, 32'hAAAA1234, 3'b001, rd, er, cyc, stl); check_val("sh_err", er, 0);
    run_req(0, 0, 32'h410, 32'h0, 3'b010, rd, er, cyc, stl); check_val("lw_wrap", rd, 32'h123455EF);

    run_req(0, 1, 32'h12, 32'h99999999, 3'b010, rd, er, cyc, stl);
    check_val("sw_mis_err", er, 1); check_val("sw_mis_rdata", rd, 0);
    run_req(0, 0, 32'h10, 32'h0, 3'b010, rd, er, cyc, stl); check_val("lw_unchanged", rd, 32'h123455EF);
    run_req(0, 0, 32'h01, 32'h0, 3'b001, rd, er, cyc, stl);
    check_val("lh_mis_err", er, 1); check_val("lh_mis_rdata", rd, 0);
    run_req(0, 0, 32'h10, 32'h0, 3'b011, rd, er, cyc, stl);
    check_val("f3_011_err", er, 1); check_val("f3_011_rdata", rd, 0);

    // Reset during BUSY with a pending store
    run_req(0, 1, 32'h20, 32'h11223344, 3'b010, rd, er, cyc, stl);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'hAAAAAAAA, 3'b010);
    @(posedge clk); #1;
    check_val("busy_ready", u_if2.req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(posedge clk); #1;
    check_val("rst_busy_valid", u_if2.resp_valid, 0);
    check_val("rst_busy_ready", u_if2.req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (u_if2.resp_valid) vcnt++;
    end
    check_val("rst_no_resp", vcnt, 0);
    run_req(0, 0, 32'h20, 32'h0, 3'b010, rd, er, cyc, stl); check_val("rst_no_write", rd, 32'h11223344);

    run_req(1, 1, 32'h40, 32'hCAFEF00D, 3'b010, rd, er, cyc, stl);
    check_val("l1_sw_lat", cyc, 1); check_val("l1_sw_stall", stl, 1); check_val("l1_sw_err", er, 0);
    run_req(1, 0, 32'h40, 32'h0, 3'b010, rd, er, cyc, stl);
    check_val("l1_lw_data", rd, 32'hCAFEF00D); check_val("l1_lw_lat", cyc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
